// File: rtl/input_conditioner.sv
// Board-side input front end: two-flop synchronisers, debouncers and press/long-press
// pulse generation for the push buttons, plus a shared-counter debouncer for the switch bank.
module input_conditioner #(
  parameter int NUM_BTN         = 3,
  parameter int SW_WIDTH        = 12,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_PRESS      = 256,
  parameter int CNT_W           = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTN-1:0]  button_raw,
  input  logic [SW_WIDTH-1:0] switch_raw,
  input  logic                mode_raw,
  input  logic [1:0]          rw_raw,
  output logic [NUM_BTN-1:0]  button_level,
  output logic [NUM_BTN-1:0]  button_press,
  output logic [NUM_BTN-1:0]  button_long,
  output logic [SW_WIDTH-1:0] switch_sync,
  output logic                mode_sync,
  output logic [1:0]          rw_sync,
  output logic                switch_changed
);

  localparam int VEC_W = SW_WIDTH + 3;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_PRESS);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS - 1);

  logic [NUM_BTN-1:0] btn_s1, btn_s2, btn_stable;
  logic [CNT_W-1:0]   btn_cnt  [NUM_BTN];
  logic [CNT_W-1:0]   hold_cnt [NUM_BTN];

  logic [VEC_W-1:0]   sw_raw_vec, sw_s1, sw_s2, sw_stable;
  logic [CNT_W-1:0]   sw_cnt;

  assign sw_raw_vec = {rw_raw, mode_raw, switch_raw};

  // Buttons idle high (released), so their synchronisers reset to all ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1 <= '1;
      btn_s2 <= '1;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= button_raw;
      btn_s2 <= btn_s1;
      sw_s1  <= sw_raw_vec;
      sw_s2  <= sw_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_stable <= '1;
      for (int i = 0; i < NUM_BTN; i++) btn_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (btn_s2[i] == btn_stable[i]) begin
          btn_cnt[i] <= '0;
        end else if (btn_cnt[i] == DB_LAST) begin
          btn_stable[i] <= btn_s2[i];
          btn_cnt[i]    <= '0;
        end else begin
          btn_cnt[i] <= btn_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press fires on the level's rising edge; long fires once as the hold count saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      button_level <= '0;
      button_press <= '0;
      button_long  <= '0;
      for (int i = 0; i < NUM_BTN; i++) hold_cnt[i] <= '0;
    end else begin
      button_level <= ~btn_stable;
      button_press <= ~btn_stable & ~button_level;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (button_level[i]) begin
          if (hold_cnt[i] != HOLD_MAX) hold_cnt[i] <= hold_cnt[i] + 1'b1;
          button_long[i] <= (hold_cnt[i] == HOLD_LAST);
        end else begin
          hold_cnt[i]    <= '0;
          button_long[i] <= 1'b0;
        end
      end
    end
  end

  // A synchroniser edge about to land (s1 != s2) restarts the shared count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_stable <= '0;
      sw_cnt    <= '0;
    end else if (sw_s2 == sw_stable) begin
      sw_cnt <= '0;
    end else if (sw_cnt == DB_LAST) begin
      sw_stable <= sw_s2;
      sw_cnt    <= '0;
    end else if (sw_s1 != sw_s2) begin
      sw_cnt <= '0;
    end else begin
      sw_cnt <= sw_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      switch_sync    <= '0;
      mode_sync      <= 1'b0;
      rw_sync        <= '0;
      switch_changed <= 1'b0;
    end else begin
      switch_sync    <= sw_stable[SW_WIDTH-1:0];
      mode_sync      <= sw_stable[SW_WIDTH];
      rw_sync        <= sw_stable[SW_WIDTH+2:SW_WIDTH+1];
      switch_changed <= (sw_stable != {rw_sync, mode_sync, switch_sync});
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a run-length behavioural model checked every cycle
// and hand-computed literal expectations at the key edges of each scenario.
module tb_input_conditioner;

  localparam int NUM_BTN  = 3;
  localparam int SW_WIDTH = 12;
  localparam int DB       = 4;
  localparam int LP       = 8;
  localparam int CNT_W    = 16;
  localparam int VW       = SW_WIDTH + 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [NUM_BTN-1:0]  button_raw;
  logic [SW_WIDTH-1:0] switch_raw;
  logic                mode_raw;
  logic [1:0]          rw_raw;
  logic [NUM_BTN-1:0]  button_level, button_press, button_long;
  logic [SW_WIDTH-1:0] switch_sync;
  logic                mode_sync;
  logic [1:0]          rw_sync;
  logic                switch_changed;

  int checks = 0;
  int failures = 0;
  int changed_seen = 0;
  int base;

  input_conditioner #(
    .NUM_BTN(NUM_BTN), .SW_WIDTH(SW_WIDTH), .DEBOUNCE_CYCLES(DB),
    .LONG_PRESS(LP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .button_raw(button_raw), .switch_raw(switch_raw),
    .mode_raw(mode_raw), .rw_raw(rw_raw), .button_level(button_level),
    .button_press(button_press), .button_long(button_long), .switch_sync(switch_sync),
    .mode_sync(mode_sync), .rw_sync(rw_sync), .switch_changed(switch_changed)
  );

  always #5 clk = ~clk;

  // Model: a value is accepted once its 2-edge-delayed copy has differed from the accepted
  // value, unchanged, for DB consecutive edges; outputs follow one edge later.
  logic [NUM_BTN-1:0] m_level, m_press, m_long, m_bstable, m_blast, m_bd1, m_bd2;
  int                 m_brun [NUM_BTN];
  int                 m_hold [NUM_BTN];
  logic [VW-1:0]      m_sd1, m_sd2, m_slast, m_sstable, m_sout;
  int                 m_srun;
  logic               m_changed;

  task automatic model_reset();
    m_level = '0; m_press = '0; m_long = '0;
    m_bstable = '1; m_blast = '1; m_bd1 = '1; m_bd2 = '1;
    for (int b = 0; b < NUM_BTN; b++) begin
      m_brun[b] = 0;
      m_hold[b] = 0;
    end
    m_sd1 = '0; m_sd2 = '0; m_slast = '0; m_sstable = '0; m_sout = '0;
    m_srun = 0; m_changed = 1'b0;
  endtask

  task automatic model_step();
    for (int b = 0; b < NUM_BTN; b++) begin
      if (m_level[b]) begin
        if (m_hold[b] < LP) begin
          m_hold[b] = m_hold[b] + 1;
          m_long[b] = (m_hold[b] == LP);
        end else begin
          m_long[b] = 1'b0;
        end
      end else begin
        m_hold[b] = 0;
        m_long[b] = 1'b0;
      end
      m_press[b] = ~m_bstable[b] & ~m_level[b];
      m_level[b] = ~m_bstable[b];
      if (m_bd2[b] != m_bstable[b]) begin
        m_brun[b] = (m_bd2[b] == m_blast[b]) ? m_brun[b] + 1 : 1;
        if (m_brun[b] == DB) begin
          m_bstable[b] = m_bd2[b];
          m_brun[b] = 0;
        end
      end else begin
        m_brun[b] = 0;
      end
      m_blast[b] = m_bd2[b];
    end
    m_bd2 = m_bd1;
    m_bd1 = button_raw;

    m_changed = (m_sstable != m_sout);
    m_sout = m_sstable;
    if (m_sd2 != m_sstable) begin
      m_srun = (m_sd2 == m_slast) ? m_srun + 1 : 1;
      if (m_srun == DB) begin
        m_sstable = m_sd2;
        m_srun = 0;
      end
    end else begin
      m_srun = 0;
    end
    m_slast = m_sd2;
    m_sd2 = m_sd1;
    m_sd1 = {rw_raw, mode_raw, switch_raw};
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) model_reset();
    else model_step();
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    check_output("cmp_level",   32'(button_level),   32'(m_level));
    check_output("cmp_press",   32'(button_press),   32'(m_press));
    check_output("cmp_long",    32'(button_long),    32'(m_long));
    check_output("cmp_switch",  32'(switch_sync),    32'(m_sout[SW_WIDTH-1:0]));
    check_output("cmp_mode",    32'(mode_sync),      32'(m_sout[SW_WIDTH]));
    check_output("cmp_rw",      32'(rw_sync),        32'(m_sout[SW_WIDTH+2:SW_WIDTH+1]));
    check_output("cmp_changed", 32'(switch_changed), 32'(m_changed));
    if (switch_changed === 1'b1) changed_seen++;
  end

  task automatic apply_stimulus(input logic [NUM_BTN-1:0] btn, input logic [SW_WIDTH-1:0] sw,
                                input logic mode, input logic [1:0] rw);
    button_raw = btn;
    switch_raw = sw;
    mode_raw   = mode;
    rw_raw     = rw;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    apply_stimulus(3'b111, 12'h000, 1'b0, 2'b00);
    wait_edges(3);
    check_output("reset_level",   32'(button_level),   32'd0);
    check_output("reset_switch",  32'(switch_sync),    32'd0);
    check_output("reset_changed", 32'(switch_changed), 32'd0);
    rst = 1'b1;
    wait_edges(10);

    $display("[TB] scenario: single long press on button 0");
    apply_stimulus(3'b110, 12'h000, 1'b0, 2'b00);
    wait_edges(6);
    check_output("t1_level_e5", 32'(button_level[0]), 32'd0);
    wait_edges(1);
    check_output("t1_level_e6", 32'(button_level[0]), 32'd1);
    check_output("t1_press_e6", 32'(button_press),    32'b001);
    wait_edges(1);
    check_output("t1_press_e7", 32'(button_press),    32'd0);
    wait_edges(6);
    check_output("t1_long_e13", 32'(button_long),     32'd0);
    wait_edges(1);
    check_output("t1_long_e14", 32'(button_long),     32'b001);
    wait_edges(1);
    check_output("t1_long_e15", 32'(button_long),     32'd0);
    wait_edges(4);
    apply_stimulus(3'b111, 12'h000, 1'b0, 2'b00);
    wait_edges(12);
    check_output("t1_released", 32'(button_level),    32'd0);

    $display("[TB] scenario: short glitch on button 1");
    apply_stimulus(3'b101, 12'h000, 1'b0, 2'b00);
    wait_edges(3);
    apply_stimulus(3'b111, 12'h000, 1'b0, 2'b00);
    wait_edges(4);
    check_output("t2_level", 32'(button_level), 32'd0);
    check_output("t2_press", 32'(button_press), 32'd0);
    wait_edges(10);

    $display("[TB] scenario: all buttons together, short hold");
    apply_stimulus(3'b000, 12'h000, 1'b0, 2'b00);
    wait_edges(5);
    apply_stimulus(3'b111, 12'h000, 1'b0, 2'b00);
    wait_edges(2);
    check_output("t3_press_all", 32'(button_press), 32'b111);
    check_output("t3_level_all", 32'(button_level), 32'b111);
    wait_edges(5);
    check_output("t3_level_rel", 32'(button_level), 32'd0);
    check_output("t3_no_long",   32'(button_long),  32'd0);
    wait_edges(10);

    $display("[TB] scenario: address change with bouncing bit 0");
    base = changed_seen;
    apply_stimulus(3'b111, 12'hABC, 1'b0, 2'b00);
    wait_edges(2);
    apply_stimulus(3'b111, 12'hABD, 1'b0, 2'b00);
    wait_edges(2);
    apply_stimulus(3'b111, 12'hABC, 1'b0, 2'b00);
    wait_edges(6);
    check_output("t4_switch_e9",  32'(switch_sync),    32'h000);
    wait_edges(1);
    check_output("t4_switch_e10", 32'(switch_sync),    32'hABC);
    check_output("t4_changed",    32'(switch_changed), 32'd1);
    wait_edges(10);
    check_output("t4_one_change", 32'(changed_seen - base), 32'd1);

    $display("[TB] scenario: reset during a held press");
    apply_stimulus(3'b110, 12'hABC, 1'b0, 2'b00);
    wait_edges(12);
    check_output("t5_level_pre", 32'(button_level[0]), 32'd1);
    rst = 1'b0;
    #1;
    check_output("t5_rst_level",  32'(button_level), 32'd0);
    check_output("t5_rst_switch", 32'(switch_sync),  32'd0);
    wait_edges(2);
    rst = 1'b1;
    base = changed_seen;
    wait_edges(6);
    check_output("t5_level_e5",  32'(button_level[0]), 32'd0);
    wait_edges(1);
    check_output("t5_press_e6",  32'(button_press),    32'b001);
    check_output("t5_switch_e6", 32'(switch_sync),     32'hABC);
    check_output("t5_changed",   32'(changed_seen - base), 32'd1);
    wait_edges(7);
    check_output("t5_long_e13",  32'(button_long),     32'd0);
    wait_edges(1);
    check_output("t5_long_e14",  32'(button_long),     32'b001);
    apply_stimulus(3'b111, 12'hABC, 1'b0, 2'b00);
    wait_edges(12);

    $display("[TB] scenario: mode and R/W switches");
    base = changed_seen;
    apply_stimulus(3'b111, 12'hABC, 1'b1, 2'b10);
    wait_edges(6);
    check_output("t6_mode_e5", 32'(mode_sync), 32'd0);
    wait_edges(1);
    check_output("t6_mode_e6", 32'(mode_sync), 32'd1);
    check_output("t6_rw_e6",   32'(rw_sync),   32'b10);
    wait_edges(10);
    check_output("t6_one_change", 32'(changed_seen - base), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
